// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: key request handshake between the SoC (master) and the keypad emulator (slave).
interface keypad_emulator_if;
  logic [3:0] key_idx;
  logic       key_valid;
  logic       key_ready;
  modport master(output key_idx, key_valid, input key_ready);
  modport slave(input key_idx, key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers a 4x4 keypad row scan as if one key were held closed for a while, then released.
module keypad_emulator #(
  parameter int PRESS_CYCLES   = 64,
  parameter int RELEASE_CYCLES = 64
) (
  input  logic                clk_Teclado,
  input  logic                rst_n,
  keypad_emulator_if.slave    req,
  input  logic [3:0]          Fila,
  output logic [3:0]          Columna,
  output logic                busy,
  output logic                done
);
  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_q, row_d, col_q, col_d;
  logic          done_q, done_d;
  logic [7:0]    map;
  always_comb begin
    case (req.key_idx)
      4'd0:    map = {4'b0001, 4'b0100};
      4'd1:    map = {4'b1000, 4'b1000};
      4'd2:    map = {4'b1000, 4'b0100};
      4'd3:    map = {4'b1000, 4'b0010};
      4'd4:    map = {4'b0100, 4'b1000};
      4'd5:    map = {4'b0100, 4'b0100};
      4'd6:    map = {4'b0100, 4'b0010};
      4'd7:    map = {4'b0010, 4'b1000};
      4'd8:    map = {4'b0010, 4'b0100};
      4'd9:    map = {4'b0010, 4'b0010};
      4'd10:   map = {4'b1000, 4'b0001};
      4'd11:   map = {4'b0100, 4'b0001};
      4'd12:   map = {4'b0010, 4'b0001};
      4'd13:   map = {4'b0001, 4'b0001};
      4'd14:   map = {4'b0001, 4'b1000};
      default: map = {4'b0001, 4'b0010};
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (req.key_valid) begin
        state_d        = PRESS;
        cnt_d          = CW'(PRESS_CYCLES - 1);
        {row_d, col_d} = map;
      end
      PRESS: if (cnt_q == '0) begin
        state_d = RELEASE;
        cnt_d   = CW'(RELEASE_CYCLES - 1);
      end else cnt_d = cnt_q - 1'b1;
      RELEASE: if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_Teclado or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end
  // All-rows scan (1111) or the exact latched row closes the switch; anything else stays open
  assign Columna       = (state_q == PRESS && (Fila == 4'b1111 || Fila == row_q)) ? col_q : 4'b0000;
  assign req.key_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed stimulus pushes expected {Columna,busy,done,key_ready}; a negedge monitor pops and compares.
module tb_keypad_emulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] Fila = 4'hF;
  logic [3:0] Columna;
  logic       busy, done;
  keypad_emulator_if bus();
  keypad_emulator #(.PRESS_CYCLES(4), .RELEASE_CYCLES(3)) dut (
    .clk_Teclado(clk), .rst_n(rst_n), .req(bus), .Fila(Fila),
    .Columna(Columna), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {string nm; logic [6:0] v;} exp_t;
  exp_t q[$];
  exp_t cur;
  int total = 0, passed = 0;
  localparam logic [6:0] IDL = 7'b0000_001;
  localparam logic [6:0] REL = 7'b0000_100;
  localparam logic [6:0] DON = 7'b0000_011;
  function automatic logic [6:0] prs(input logic [3:0] c);
    return {c, 3'b100};
  endfunction
  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      total++;
      if ({Columna, busy, done, bus.key_ready} === cur.v) passed++;
      else $display("FAIL %s: got col=%b busy=%b done=%b ready=%b, want col=%b busy=%b done=%b ready=%b",
                    cur.nm, Columna, busy, done, bus.key_ready, cur.v[6:3], cur.v[2], cur.v[1], cur.v[0]);
    end
  end
  task automatic cyc(input logic r, input logic [3:0] f, input logic v, input logic [3:0] k,
                     input logic [6:0] e, input string nm);
    @(posedge clk);
    #2;
    rst_n = r;
    Fila = f;
    bus.key_valid = v;
    bus.key_idx = k;
    q.push_back('{nm, e});
  endtask
  initial begin
    bus.key_valid = 1'b0;
    bus.key_idx = 4'd0;
    repeat (3) cyc(0, 4'hF, 0, 0, IDL, "rst_hold");
    repeat (2) cyc(1, 4'hF, 0, 0, IDL, "rst_after");
    cyc(1, 4'hF, 1, 5, IDL, "k5_req");
    repeat (4) cyc(1, 4'hF, 0, 5, prs(4'b0100), "k5_press");
    repeat (3) cyc(1, 4'hF, 0, 5, REL, "k5_rel");
    cyc(1, 4'hF, 0, 5, DON, "k5_done");
    cyc(1, 4'hF, 0, 5, IDL, "k5_idle");
    cyc(1, 4'hF, 1, 14, IDL, "k14_req");
    cyc(1, 4'b1000, 0, 14, prs(4'b0000), "k14_f1000");
    cyc(1, 4'b0100, 0, 14, prs(4'b0000), "k14_f0100");
    cyc(1, 4'b0010, 0, 14, prs(4'b0000), "k14_f0010");
    cyc(1, 4'b0001, 0, 14, prs(4'b1000), "k14_f0001");
    repeat (3) cyc(1, 4'b0001, 0, 14, REL, "k14_rel_row_match");
    cyc(1, 4'hF, 0, 14, DON, "k14_done");
    cyc(1, 4'hF, 1, 14, IDL, "k14b_req");
    cyc(1, 4'b0011, 0, 14, prs(4'b0000), "k14_f0011");
    cyc(1, 4'b0000, 0, 14, prs(4'b0000), "k14_f0000");
    cyc(1, 4'hF, 0, 14, prs(4'b1000), "k14_f1111");
    cyc(1, 4'b0001, 0, 14, prs(4'b1000), "k14b_f0001");
    repeat (3) cyc(1, 4'hF, 0, 14, REL, "k14b_rel");
    cyc(1, 4'hF, 0, 14, DON, "k14b_done");
    cyc(1, 4'b1000, 1, 1, IDL, "k1_req");
    repeat (4) cyc(1, 4'b1000, 1, 9, prs(4'b1000), "k1_ignore_req");
    repeat (3) cyc(1, 4'b1000, 0, 9, REL, "k1_rel");
    cyc(1, 4'b1000, 0, 9, DON, "k1_done");
    repeat (2) cyc(1, 4'b1000, 0, 9, IDL, "k1_no_repress");
    cyc(1, 4'hF, 1, 1, IDL, "b2b_req");
    repeat (4) cyc(1, 4'hF, 1, 1, prs(4'b1000), "b2b_p1");
    repeat (3) cyc(1, 4'hF, 1, 1, REL, "b2b_rel1");
    cyc(1, 4'hF, 1, 15, DON, "b2b_done1");
    cyc(1, 4'b0001, 0, 15, prs(4'b0010), "b2b_f0001");
    cyc(1, 4'hF, 0, 15, prs(4'b0010), "b2b_f1111");
    cyc(1, 4'b1000, 0, 15, prs(4'b0000), "b2b_f1000");
    cyc(1, 4'hF, 0, 15, prs(4'b0010), "b2b_f1111b");
    repeat (3) cyc(1, 4'hF, 0, 15, REL, "b2b_rel2");
    cyc(1, 4'hF, 0, 15, DON, "b2b_done2");
    cyc(1, 4'hF, 0, 15, IDL, "b2b_idle");
    cyc(1, 4'b0001, 1, 13, IDL, "k13_req");
    cyc(1, 4'b0001, 0, 13, prs(4'b0001), "k13_press");
    cyc(0, 4'b0001, 0, 13, IDL, "k13_abort");
    cyc(0, 4'b0001, 0, 13, IDL, "k13_abort_hold");
    repeat (9) cyc(1, 4'b0001, 0, 13, IDL, "k13_no_done");
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
